// File: rtl/bit_serial_sub_ctrl.sv
// rtl/bit_serial_sub_ctrl.sv - bit-serial PIM subtraction engine around one shared 1-bit subtractor cell
// Optional signed-overflow output enabled by defining BSSUB_OVF_EN.

// Single-bit subtractor: Sub = A - B - Bin (mod 2), Bout = borrow out.
module subtractor_1bit #(
  parameter int IMPL_TYPE = 0
) (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic sub_o,
  output logic bout_o
);

  generate
    if (IMPL_TYPE == 1) begin : g_maj
      // Subtract as A + ~B + ~Bin built from majority gates and inverters.
      logic x, y, c, co, m;
      assign x      = a_i;
      assign y      = ~b_i;
      assign c      = ~bin_i;
      assign co     = (x & y) | (x & c) | (y & c);
      assign m      = (x & y) | (x & ~c) | (y & ~c);
      assign sub_o  = (~co & c) | (~co & m) | (c & m);
      assign bout_o = ~co;
    end else begin : g_xor
      // Difference by XOR, borrow selected by a mux on the incoming borrow.
      assign sub_o  = a_i ^ b_i ^ bin_i;
      assign bout_o = bin_i ? (~a_i | b_i) : (~a_i & b_i);
    end
  endgenerate

endmodule

module bit_serial_sub_ctrl #(
  parameter int WIDTH     = 8,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef BSSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             brw_q;
  logic [CW-1:0]    cnt_q;
  logic             cell_sub;
  logic             cell_bout;
`ifdef BSSUB_OVF_EN
  logic             ovf_q;
`endif

  // The one shared cell always looks at the current LSBs and the borrow flop.
  subtractor_1bit #(
    .IMPL_TYPE(IMPL_TYPE)
  ) u_cell (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .bin_i (brw_q),
    .sub_o (cell_sub),
    .bout_o(cell_bout)
  );

  // Sequencer: accept operands, shift one bit per cycle, hold result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef BSSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            brw_q   <= bin;
            diff_q  <= '0;
            cnt_q   <= '0;
`ifdef BSSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          brw_q  <= cell_bout;
          diff_q <= {cell_sub, diff_q[WIDTH-1:1]};
          if (cnt_q == LAST_BIT) begin
            // Counter stays at the last index so it never wraps.
            state_q <= DONE;
`ifdef BSSUB_OVF_EN
            // On the last bit the LSBs hold the original operand MSBs.
            ovf_q   <= (a_q[0] ^ b_q[0]) & (cell_sub ^ a_q[0]);
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign diff      = diff_q;
  assign bout      = brw_q;
`ifdef BSSUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_sub_ctrl.sv
// tb/tb_bit_serial_sub_ctrl.sv - directed self-checking bench for bit_serial_sub_ctrl
// Define BSSUB_OVF_EN to also exercise the overflow flag.
module tb_bit_serial_sub_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, out_ready, bin;
  logic [7:0] a, b;
  logic       rdy_x, val_x, busy_x, bout_x;
  logic [7:0] diff_x;
  logic       rdy_y, val_y, busy_y, bout_y;
  logic [7:0] diff_y;
`ifdef BSSUB_OVF_EN
  logic       ovf_x, ovf_y, ovf_z;
`endif

  logic       in_valid2, out_ready2, bin2;
  logic [1:0] a2, b2;
  logic       rdy_z, val_z, busy_z, bout_z;
  logic [1:0] diff_z;

  int n_cmp  = 0;
  int n_fail = 0;

  bit_serial_sub_ctrl #(.WIDTH(8), .IMPL_TYPE(0)) dut_x (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_x),
    .a(a), .b(b), .bin(bin), .out_valid(val_x), .out_ready(out_ready),
    .diff(diff_x), .bout(bout_x),
`ifdef BSSUB_OVF_EN
    .ovf(ovf_x),
`endif
    .busy(busy_x)
  );

  bit_serial_sub_ctrl #(.WIDTH(8), .IMPL_TYPE(1)) dut_y (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_y),
    .a(a), .b(b), .bin(bin), .out_valid(val_y), .out_ready(out_ready),
    .diff(diff_y), .bout(bout_y),
`ifdef BSSUB_OVF_EN
    .ovf(ovf_y),
`endif
    .busy(busy_y)
  );

  bit_serial_sub_ctrl #(.WIDTH(2), .IMPL_TYPE(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(rdy_z),
    .a(a2), .b(b2), .bin(bin2), .out_valid(val_z), .out_ready(out_ready2),
    .diff(diff_z), .bout(bout_z),
`ifdef BSSUB_OVF_EN
    .ovf(ovf_z),
`endif
    .busy(busy_z)
  );

  task automatic start_op(input logic [7:0] va, input logic [7:0] vb, input logic vbin);
    @(negedge clk);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!val_x && lat < 40) begin
      if (busy_x) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if ({rdy_x, val_x, busy_x, bout_x, diff_x} !== {3'b100, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL reset_x got %b_%h want 1000_00", {rdy_x, val_x, busy_x, bout_x}, diff_x); end
    n_cmp++; if ({rdy_y, val_y, busy_y, bout_y, diff_y} !== {3'b100, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL reset_y got %b_%h want 1000_00", {rdy_y, val_y, busy_y, bout_y}, diff_y); end
    n_cmp++; if ({rdy_z, val_z, busy_z, bout_z, diff_z} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_z got %b want 100000", {rdy_z, val_z, busy_z, bout_z, diff_z}); end
`ifdef BSSUB_OVF_EN
    n_cmp++; if ({ovf_x, ovf_y, ovf_z} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ovf got %b want 000", {ovf_x, ovf_y, ovf_z}); end
`endif
  endtask

  task automatic test_subtract(input string nm, input logic [7:0] va, input logic [7:0] vb,
                               input logic vbin, input logic [7:0] ed, input logic eb);
    int lat, bcnt;
    start_op(va, vb, vbin);
    wait_done(lat, bcnt);
    n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL %s_latency got %0d want 8", nm, lat); end
    n_cmp++; if (bcnt !== 8) begin n_fail++; $display("FAIL %s_busy_cycles got %0d want 8", nm, bcnt); end
    n_cmp++; if ({diff_x, bout_x} !== {ed, eb}) begin
      n_fail++; $display("FAIL %s_x got diff=%h bout=%b want diff=%h bout=%b", nm, diff_x, bout_x, ed, eb); end
    n_cmp++; if ({val_y, diff_y, bout_y} !== {1'b1, ed, eb}) begin
      n_fail++; $display("FAIL %s_y got v=%b diff=%h bout=%b want v=1 diff=%h bout=%b", nm, val_y, diff_y, bout_y, ed, eb); end
    n_cmp++; if ({rdy_x, busy_x} !== 2'b00) begin
      n_fail++; $display("FAIL %s_done_flags got %b want 00", nm, {rdy_x, busy_x}); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if ({rdy_x, val_x, rdy_y, val_y} !== 4'b1010) begin
      n_fail++; $display("FAIL %s_consume got %b want 1010", nm, {rdy_x, val_x, rdy_y, val_y}); end
  endtask

`ifdef BSSUB_OVF_EN
  task automatic test_ovf(input string nm, input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] ed, input logic eb, input logic eo);
    int lat, bcnt;
    start_op(va, vb, 1'b0);
    wait_done(lat, bcnt);
    n_cmp++; if ({diff_x, bout_x, ovf_x} !== {ed, eb, eo}) begin
      n_fail++; $display("FAIL %s_x got diff=%h bout=%b ovf=%b want %h %b %b", nm, diff_x, bout_x, ovf_x, ed, eb, eo); end
    n_cmp++; if ({diff_y, bout_y, ovf_y} !== {ed, eb, eo}) begin
      n_fail++; $display("FAIL %s_y got diff=%h bout=%b ovf=%b want %h %b %b", nm, diff_y, bout_y, ovf_y, ed, eb, eo); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
`endif

  task automatic test_backpressure();
    int lat, bcnt;
    start_op(8'h3C, 8'h15, 1'b0);
    wait_done(lat, bcnt);
    for (int i = 0; i < 5; i++) begin
      a = 8'(i * 37); b = 8'(~i); bin = i[0]; in_valid = ~i[0];
      @(negedge clk);
      n_cmp++; if ({val_x, rdy_x, diff_x, bout_x, val_y, diff_y} !== {2'b10, 8'h27, 1'b0, 1'b1, 8'h27}) begin
        n_fail++; $display("FAIL bp_hold_%0d got v=%b r=%b diff=%h bout=%b diff_y=%h want v=1 r=0 diff=27 bout=0",
                           i, val_x, rdy_x, diff_x, bout_x, diff_y); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if ({rdy_x, val_x, busy_x} !== 3'b100) begin
      n_fail++; $display("FAIL bp_release got %b want 100", {rdy_x, val_x, busy_x}); end
    @(negedge clk);
    n_cmp++; if ({rdy_x, busy_x} !== 2'b10) begin
      n_fail++; $display("FAIL bp_stays_idle got %b want 10", {rdy_x, busy_x}); end
  endtask

  task automatic test_reset_mid_run();
    start_op(8'hFF, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({rdy_x, val_x, busy_x, bout_x, diff_x, diff_y} !== {4'b1000, 16'h0000}) begin
      n_fail++; $display("FAIL midrst_async got %b diff=%h diff_y=%h want 1000 00 00",
                         {rdy_x, val_x, busy_x, bout_x}, diff_x, diff_y); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({rdy_x, val_x, rdy_y, val_y} !== 4'b1010) begin
      n_fail++; $display("FAIL midrst_release got %b want 1010", {rdy_x, val_x, rdy_y, val_y}); end
    test_subtract("after_rst", 8'hA0, 8'h0A, 1'b0, 8'h96, 1'b0);
  endtask

  task automatic test_width2(input logic [1:0] va, input logic [1:0] vb, input logic vbin,
                             input logic [1:0] ed, input logic eb);
    int lat;
    @(negedge clk);
    a2 = va; b2 = vb; bin2 = vbin; in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    lat = 0;
    while (!val_z && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL w2_latency got %0d want 2", lat); end
    n_cmp++; if ({diff_z, bout_z} !== {ed, eb}) begin
      n_fail++; $display("FAIL w2_result got diff=%h bout=%b want diff=%h bout=%b", diff_z, bout_z, ed, eb); end
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    n_cmp++; if ({rdy_z, val_z} !== 2'b10) begin
      n_fail++; $display("FAIL w2_consume got %b want 10", {rdy_z, val_z}); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_subtract("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    test_subtract("sub_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    test_subtract("sub_10_0F_b", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
    test_backpressure();
    test_reset_mid_run();
`ifdef BSSUB_OVF_EN
    test_ovf("ovf_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    test_ovf("ovf_7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    test_ovf("ovf_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
`endif
    test_width2(2'd0, 2'd3, 1'b1, 2'd0, 1'b1);
    test_width2(2'd3, 2'd1, 1'b0, 2'd2, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
